boot_sched: RTL and testbench

//  Multiboot scheduler in front of the Spartan-6 ICAP. Arbitrates reboot requests from NREQ

---
 rtl/boot_pkg.sv | 35 +++
 rtl/boot_req_qual.sv | 43 ++++
 rtl/boot_sched.sv | 210 +++++++++++++++++++++
 tb/tb_boot_sched.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared constants, state type and helpers for the multiboot scheduler
package boot_pkg;

  localparam int SLOT_W = 2;
  localparam int IDX_W  = 4;
  localparam int NWORDS = 14;

  // ICAP command words, written here in the Xilinx documentation bit order
  localparam logic [15:0] SYNC1     = 16'hAA99;
  localparam logic [15:0] SYNC2     = 16'h5566;
  localparam logic [15:0] CMD_WR    = 16'h30A1;
  localparam logic [15:0] NUL       = 16'h0000;
  localparam logic [15:0] GEN1_WR   = 16'h3261;
  localparam logic [15:0] GEN2_WR   = 16'h3281;
  localparam logic [15:0] IPROG     = 16'h000E;
  localparam logic [15:0] NOOP      = 16'h2000;
  localparam logic [15:0] IDLE_WORD = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // ICAP_SPARTAN6 expects each byte with its bits mirrored
  function automatic logic [15:0] byte_rev(input logic [15:0] w);
    logic [15:0] r;
    for (int b = 0; b < 8; b++) begin
      r[b]     = w[7 - b];
      r[8 + b] = w[15 - b];
    end
    return r;
  endfunction

endpackage

// File: rtl/boot_req_qual.sv
// rtl/boot_req_qual.sv - per-source request hold counter and re-arm flag
module boot_req_qual
  import boot_pkg::*;
#(
  parameter int HOLD = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic ce,
  input  logic req,
  input  logic take,
  output logic qual
);

  localparam int CW = $clog2(HOLD + 1);
  localparam logic [CW-1:0] HOLD_C = CW'(HOLD);

  logic [CW-1:0] cnt;
  logic          armed;

  // Count consecutive ce cycles with req high; a low sample clears and re-arms,
  // being served disarms until the source lets go of req.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      armed <= 1'b1;
    end else if (ce) begin
      if (!req) begin
        cnt <= '0;
      end else if (cnt != HOLD_C) begin
        cnt <= cnt + 1'b1;
      end
      if (take) begin
        armed <= 1'b0;
      end else if (!req) begin
        armed <= 1'b1;
      end
    end
  end

  assign qual = (cnt == HOLD_C) && armed;

endmodule

// File: rtl/boot_sched.sv
// rtl/boot_sched.sv - round-robin multiboot scheduler driving the Spartan-6 ICAP
module boot_sched
  import boot_pkg::*;
#(
  parameter int          NREQ   = 2,
  parameter int          HOLD   = 4,
  parameter int          GUARD  = 1024,
  parameter logic [23:0] ADDR0  = 24'h000000,
  parameter logic [23:0] ADDR1  = 24'h058000,
  parameter logic [23:0] ADDR2  = 24'h058000,
  parameter logic [23:0] ADDR3  = 24'h058000,
  parameter logic [7:0]  OPCODE = 8'h03
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     ce,
  input  logic [NREQ-1:0]          req,
  input  logic [SLOT_W*NREQ-1:0]   slot,
  input  logic                     lock,
  output logic [NREQ-1:0]          grant,
  output logic                     busy,
  output logic                     icap_ce,
  output logic                     icap_wr,
  output logic [15:0]              icap_din
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GW    = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [IDX_W-1:0] END_IDX   = IDX_W'(NWORDS);
  localparam logic [GW-1:0]    GUARD_END = GW'(GUARD - 1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NREQ - 1);

  state_t             state, state_n;
  logic [IDX_W-1:0]   idx;
  logic [GW-1:0]      guard_cnt;
  logic [23:0]        addr;
  logic [PTR_W-1:0]   ptr;
  logic [NREQ-1:0]    qual;
  logic [NREQ-1:0]    take;
  logic               any_qual;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   arb_hi;
  logic [PTR_W-1:0]   arb_lo;
  logic               arb_found_hi;
  logic [NREQ-1:0]    win_oh;
  logic [SLOT_W-1:0]  win_slot;
  logic [15:0]        word;
  logic               start;
  logic               step;
  logic               end_send;
  logic               drain_done;

  genvar g;
  generate
    for (g = 0; g < NREQ; g++) begin : g_qual
      boot_req_qual #(.HOLD(HOLD)) u_qual (
        .clock (clock),
        .reset (reset),
        .ce    (ce),
        .req   (req[g]),
        .take  (take[g]),
        .qual  (qual[g])
      );
    end
  endgenerate

  function automatic logic [23:0] slot_addr(input logic [SLOT_W-1:0] s);
    case (s)
      2'd0:    return ADDR0;
      2'd1:    return ADDR1;
      2'd2:    return ADDR2;
      default: return ADDR3;
    endcase
  endfunction

  // Round-robin pick: lowest qualified index at or above ptr, else lowest below it.
  always_comb begin
    arb_hi       = '0;
    arb_lo       = '0;
    arb_found_hi = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (qual[i]) begin
        if (PTR_W'(i) >= ptr) begin
          arb_hi       = PTR_W'(i);
          arb_found_hi = 1'b1;
        end else begin
          arb_lo = PTR_W'(i);
        end
      end
    end
    win_idx = arb_found_hi ? arb_hi : arb_lo;
    win_oh  = '0;
    win_oh[win_idx] = 1'b1;
    win_slot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == PTR_W'(i)) begin
        win_slot = slot[i*SLOT_W +: SLOT_W];
      end
    end
  end

  assign any_qual = |qual;
  assign take     = start ? win_oh : '0;
  assign busy     = (state != IDLE);

  // Command ROM; idx always names the word to present on the next ce in SEND.
  always_comb begin
    word = IDLE_WORD;
    case (idx)
      4'd0:  word = SYNC1;
      4'd1:  word = SYNC2;
      4'd2:  word = CMD_WR;
      4'd3:  word = NUL;
      4'd4:  word = GEN1_WR;
      4'd5:  word = addr[15:0];
      4'd6:  word = GEN2_WR;
      4'd7:  word = {OPCODE, addr[23:16]};
      4'd8:  word = CMD_WR;
      4'd9:  word = IPROG;
      4'd10: word = NOOP;
      4'd11: word = NOOP;
      4'd12: word = NOOP;
      4'd13: word = NOOP;
      default: word = IDLE_WORD;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and per-edge control strobes
  always_comb begin
    state_n    = state;
    start      = 1'b0;
    step       = 1'b0;
    end_send   = 1'b0;
    drain_done = 1'b0;
    case (state)
      IDLE: begin
        if (ce && !lock && any_qual) begin
          start   = 1'b1;
          state_n = SEND;
        end
      end
      SEND: begin
        if (ce) begin
          if (idx == END_IDX) begin
            end_send = 1'b1;
            state_n  = DRAIN;
          end else begin
            step = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (ce && guard_cnt == GUARD_END) begin
          drain_done = 1'b1;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Grant, address latch, RR pointer, guard timer and registered ICAP port
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx       <= '0;
      guard_cnt <= '0;
      addr      <= '0;
      ptr       <= '0;
      grant     <= '0;
      icap_ce   <= 1'b1;
      icap_wr   <= 1'b1;
      icap_din  <= IDLE_WORD;
    end else begin
      if (start) begin
        addr     <= slot_addr(win_slot);
        grant    <= win_oh;
        ptr      <= (win_idx == PTR_LAST) ? '0 : win_idx + 1'b1;
        idx      <= IDX_W'(1);
        icap_ce  <= 1'b0;
        icap_wr  <= 1'b0;
        icap_din <= byte_rev(SYNC1);
      end
      if (step) begin
        icap_din <= byte_rev(word);
        idx      <= idx + 1'b1;
      end
      if (end_send) begin
        icap_ce   <= 1'b1;
        icap_wr   <= 1'b1;
        icap_din  <= IDLE_WORD;
        guard_cnt <= '0;
      end
      if (drain_done) begin
        grant <= '0;
      end else if (state == DRAIN && ce) begin
        guard_cnt <= guard_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_boot_sched.sv
// tb/tb_boot_sched.sv - scoreboard bench for boot_sched against a behavioural reference model
module tb_boot_sched;

  localparam int          NREQ  = 2;
  localparam int          HOLD  = 4;
  localparam int          GUARD = 16;
  localparam logic [23:0] A0    = 24'h000000;
  localparam logic [23:0] A1    = 24'h058000;
  localparam logic [23:0] A2    = 24'h123456;
  localparam logic [23:0] A3    = 24'hABCDEF;
  localparam logic [7:0]  OPC   = 8'h03;

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic                ce    = 1'b0;
  logic                lock  = 1'b0;
  logic [NREQ-1:0]     req   = '0;
  logic [2*NREQ-1:0]   slot  = '0;
  logic [NREQ-1:0]     grant;
  logic                busy;
  logic                icap_ce;
  logic                icap_wr;
  logic [15:0]         icap_din;

  always #5 clock = ~clock;

  boot_sched #(
    .NREQ(NREQ), .HOLD(HOLD), .GUARD(GUARD),
    .ADDR0(A0), .ADDR1(A1), .ADDR2(A2), .ADDR3(A3), .OPCODE(OPC)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .ce       (ce),
    .req      (req),
    .slot     (slot),
    .lock     (lock),
    .grant    (grant),
    .busy     (busy),
    .icap_ce  (icap_ce),
    .icap_wr  (icap_wr),
    .icap_din (icap_din)
  );

  typedef struct {
    logic [15:0]     w;
    logic [NREQ-1:0] g;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] seen_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          busy_cnt = 0;

  // reference model state
  int              m_cnt[NREQ];
  bit              m_arm[NREQ];
  int              m_ptr;
  int              m_rem;
  logic [NREQ-1:0] m_grant;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] brev(input logic [15:0] w);
    logic [15:0] r;
    for (int b = 0; b < 16; b++) r[b] = w[(b / 8) * 8 + 7 - (b % 8)];
    return r;
  endfunction

  function automatic logic [23:0] addr_of(input logic [1:0] s);
    logic [23:0] t[4];
    t = '{A0, A1, A2, A3};
    return t[s];
  endfunction

  function automatic logic [15:0] cmd_word(input int k, input logic [23:0] a);
    logic [15:0] t[14];
    t = '{16'hAA99, 16'h5566, 16'h30A1, 16'h0000, 16'h3261, a[15:0], 16'h3281,
          {OPC, a[23:16]}, 16'h30A1, 16'h000E, 16'h2000, 16'h2000, 16'h2000, 16'h2000};
    return t[k];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) begin
      m_cnt[i] = 0;
      m_arm[i] = 1'b1;
    end
    m_ptr   = 0;
    m_rem   = 0;
    m_grant = '0;
    exp_q.delete();
  endtask

  // One ce-qualified step of the reference: decide on pre-edge qualification, then update holds.
  task automatic model_step();
    int w;
    logic [23:0] a;
    logic [NREQ-1:0] oh;
    exp_t e;
    w = -1;
    if (m_rem == 0 && !lock) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (w < 0 && m_cnt[i] == HOLD && m_arm[i]) w = i;
      end
    end
    if (w >= 0) begin
      a  = addr_of(slot[2*w +: 2]);
      oh = '0;
      oh[w] = 1'b1;
      for (int k = 0; k < 14; k++) begin
        e.w = brev(cmd_word(k, a));
        e.g = oh;
        exp_q.push_back(e);
      end
      m_grant = oh;
      m_rem   = 14 + GUARD;
      m_ptr   = (w + 1) % NREQ;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) m_grant = '0;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (req[i]) m_cnt[i] = (m_cnt[i] < HOLD) ? m_cnt[i] + 1 : HOLD;
      else        m_cnt[i] = 0;
      if (i == w)       m_arm[i] = 1'b0;
      else if (!req[i]) m_arm[i] = 1'b1;
    end
  endtask

  // stimulus side: advance the reference on every ce-qualified edge
  always @(posedge clock) begin
    if (reset && ce) model_step();
  end

  // monitor: compare what the DUT presents after each ce-qualified edge
  logic mon_ce;
  exp_t mon_e;
  always @(posedge clock) begin
    mon_ce = ce && reset;
    #1;
    if (mon_ce && reset) begin
      if (!icap_ce) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got %h expected none at %0t", icap_din, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("word", icap_din, mon_e.w);
          check("word_grant", grant, mon_e.g);
          check("icap_wr_low", icap_wr, 1'b0);
        end
        seen_q.push_back(icap_din);
      end else begin
        check("idle_din", icap_din, 16'hFFFF);
        check("idle_wr", icap_wr, 1'b1);
      end
      check("busy", busy, m_rem > 0);
      check("grant", grant, m_grant);
      if (busy) busy_cnt++;
    end
  end

  // sets ce for the coming posedge and returns at the following negedge
  task automatic ce_edge(input logic c);
    ce = c;
    @(negedge clock);
  endtask

  task automatic run_ce(input int n, input int gap);
    repeat (n) begin
      repeat (gap) ce_edge(1'b0);
      ce_edge(1'b1);
    end
  endtask

  task automatic wait_idle(input int gap);
    int k;
    k = 0;
    while ((busy || m_rem > 0) && k < 4 * (GUARD + 20)) begin
      repeat (gap) ce_edge(1'b0);
      ce_edge(1'b1);
      k++;
    end
    if (busy || m_rem > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: busy=%0b model_rem=%0d", busy, m_rem);
    end
  endtask

  task automatic mid_reset(input string tag);
    #2 reset = 1'b0;
    #1;
    check({tag, "_icap_ce"}, icap_ce, 1'b1);
    check({tag, "_icap_wr"}, icap_wr, 1'b1);
    check({tag, "_icap_din"}, icap_din, 16'hFFFF);
    check({tag, "_grant"}, grant, '0);
    check({tag, "_busy"}, busy, 1'b0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [15:0] t1_words[14];
  logic [15:0] frozen;

  initial begin
    t1_words = '{16'h5599, 16'hAA66, 16'h0C85, 16'h0000, 16'h4C86, 16'h0100, 16'h4C81,
                 16'hC0A0, 16'h0C85, 16'h0070, 16'h0400, 16'h0400, 16'h0400, 16'h0400};
    model_reset();
    repeat (3) @(negedge clock);
    check("rst_icap_ce", icap_ce, 1'b1);
    check("rst_icap_wr", icap_wr, 1'b1);
    check("rst_icap_din", icap_din, 16'hFFFF);
    check("rst_grant", grant, '0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b1;
    @(negedge clock);

    // 1: single source, ce every second clock, slot 1
    seen_q.delete();
    busy_cnt = 0;
    slot = 4'b0001;
    req  = 2'b01;
    run_ce(5, 1);
    check("t1_grant", grant, 2'b01);
    req = 2'b00;
    wait_idle(1);
    check("t1_word_count", seen_q.size(), 14);
    for (int k = 0; k < 14 && k < seen_q.size(); k++) check("t1_word_value", seen_q[k], t1_words[k]);
    check("t1_busy_len", busy_cnt, 14 + GUARD);
    check("t1_grant_clear", grant, '0);

    // 2: short request is ignored, full hold is served
    req = 2'b01;
    run_ce(3, 0);
    req = 2'b00;
    run_ce(1, 0);
    check("t2_short_icap_ce", icap_ce, 1'b1);
    check("t2_short_grant", grant, '0);
    req = 2'b01;
    run_ce(5, 0);
    check("t2_grant", grant, 2'b01);
    req = 2'b00;
    wait_idle(0);

    // 3: simultaneous qualification, fairness and no re-serve without release
    @(negedge clock);
    mid_reset("t3_rst");
    req  = 2'b11;
    slot = 4'b1110;
    run_ce(5, 0);
    check("t3_first", grant, 2'b01);
    wait_idle(0);
    ce_edge(1'b1);
    check("t3_second", grant, 2'b10);
    wait_idle(0);
    run_ce(10, 0);
    check("t3_no_reserve_grant", grant, '0);
    check("t3_no_reserve_ce", icap_ce, 1'b1);
    req = 2'b00;
    run_ce(1, 0);

    // 4: lock holds off a qualified source; release grants on that edge
    lock = 1'b1;
    req  = 2'b10;
    slot = 4'b1100;
    run_ce(50, 0);
    check("t4_locked_grant", grant, '0);
    check("t4_locked_busy", busy, 1'b0);
    lock = 1'b0;
    ce_edge(1'b1);
    check("t4_release_grant", grant, 2'b10);
    req = 2'b00;
    wait_idle(0);

    // 5: reset while word 5 is on the port, then a clean restart
    req  = 2'b01;
    slot = 4'b0011;
    run_ce(5, 0);
    run_ce(5, 0);
    check("t5_word5", icap_din, brev(A3[15:0]));
    mid_reset("t5_rst");
    run_ce(4, 0);
    check("t5_requal_grant", grant, '0);
    ce_edge(1'b1);
    check("t5_restart_grant", grant, 2'b01);
    check("t5_restart_word0", icap_din, 16'h5599);
    req = 2'b00;
    wait_idle(0);

    // 6: ce stall mid-sequence with slot and lock churning
    req  = 2'b01;
    slot = 4'b0010;
    run_ce(5, 0);
    run_ce(3, 0);
    frozen = icap_din;
    for (int k = 0; k < 7; k++) begin
      slot = 4'($urandom);
      lock = ~lock;
      ce_edge(1'b0);
      check("t6_frozen_din", icap_din, frozen);
      check("t6_frozen_ce", icap_ce, 1'b0);
    end
    lock = 1'b0;
    req  = 2'b00;
    wait_idle(0);

    // randomized traffic against the reference model
    for (int it = 0; it < 1500; it++) begin
      for (int i = 0; i < NREQ; i++) if ($urandom_range(7) == 0) req[i] = ~req[i];
      if ($urandom_range(5) == 0) slot = 4'($urandom);
      if ($urandom_range(9) == 0) lock = ~lock;
      ce_edge($urandom_range(3) != 0);
    end
    lock = 1'b0;
    req  = 2'b00;
    wait_idle(0);
    run_ce(2, 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
